// File: rtl/alu_pkg.sv
// alu_pkg: shared width and opcode definitions for the execute-stage ALU
package alu_pkg;
  localparam int WIDTH = 16;
  typedef logic [1:0] alu_op_t;
  localparam alu_op_t ALU_AND  = 2'b00;
  localparam alu_op_t ALU_ADD  = 2'b01;
  localparam alu_op_t ALU_SUB  = 2'b10;
  localparam alu_op_t ALU_RSVD = 2'b11;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational two's-complement adder/subtractor (a + b or a + ~b + 1)
module alu_addsub
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);
  logic [W-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {carry_out, sum} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
  // inverting b folds the add and subtract overflow rules into one check
  assign overflow = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered 16-bit AND/ADD/SUB ALU with status flags and valid qualifier
module alu_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal_op,
  output logic             out_valid
);
  logic [WIDTH-1:0] sum, next_result;
  logic             carry_out, as_ovf, next_carry, next_ovf, is_add, is_sub;

  assign is_add = alu_op == ALU_ADD;
  assign is_sub = alu_op == ALU_SUB;

  alu_addsub #(.W(WIDTH)) u_addsub (
    .a         (a),
    .b         (b),
    .sub       (is_sub),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (as_ovf)
  );

  // opcode mux; subtract reports borrow, the inverse of the adder carry
  always_comb begin
    next_result = alu_op == ALU_AND ? (a & b) : (is_add || is_sub) ? sum : '0;
    next_carry  = is_add ? carry_out : is_sub ? ~carry_out : 1'b0;
    next_ovf    = (is_add || is_sub) && as_ovf;
  end

  // load on valid input, otherwise hold results and drop out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result     <= next_result;
        zero       <= next_result == '0;
        negative   <= next_result[WIDTH-1];
        carry      <= next_carry;
        overflow   <= next_ovf;
        illegal_op <= alu_op == ALU_RSVD;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: randomized and directed self-checking bench for alu_unit
module tb_alu_unit;
  logic        clk, rst_n, in_valid;
  logic [15:0] a, b;
  logic [1:0]  alu_op;
  logic [15:0] result;
  logic        zero, negative, carry, overflow, illegal_op, out_valid;
  logic [21:0] obs;
  int          total = 0;
  int          bad = 0;

  alu_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .result     (result),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .illegal_op (illegal_op),
    .out_valid  (out_valid)
  );

  assign obs = {result, zero, negative, carry, overflow, illegal_op, out_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: {result, zero, negative, carry, overflow, illegal_op, out_valid=1}
  function automatic logic [21:0] model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
    int ux, uy, sx, sy, t, s;
    logic [15:0] r;
    logic c, v, ill;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    r = '0; c = 0; v = 0; ill = 0;
    if (op == 2'd0) r = x & y;
    else if (op == 2'd1) begin
      t = ux + uy; s = sx + sy;
      r = t[15:0]; c = t > 65535; v = s > 32767 || s < -32768;
    end else if (op == 2'd2) begin
      t = ux - uy; s = sx - sy;
      r = t[15:0]; c = ux < uy; v = s > 32767 || s < -32768;
    end else ill = 1;
    return {r, r == 16'd0, r[15], c, v, ill, 1'b1};
  endfunction

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic [1:0] op);
    in_valid = v; a = x; b = y; alu_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 2'($urandom));
      total++;
      if (obs !== 22'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, 22'd0); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'($urandom), 16'($urandom), 2'($urandom));
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, 22'd0); end
  endtask

  task automatic test_reg_path();
    logic [21:0] exp [3];
    exp[0] = {16'h0006, 6'b000001};
    exp[1] = {16'h0005, 6'b001001};
    exp[2] = {16'h0019, 6'b001001};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd15, 16'hFFF6, 2'(i));
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL reg_path op=%0d got=%h want=%h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp [3];
    exp[0] = {16'h0005, 6'b000001};
    exp[1] = {16'h0014, 6'b000001};
    exp[2] = {16'h000A, 6'b000001};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd15, 16'd5, 2'(i));
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL imm_b2b op=%0d got=%h want=%h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_flags();
    drive(1'b1, 16'h7FFF, 16'h0001, 2'd1);
    total++;
    if (obs !== {16'h8000, 6'b010101}) begin bad++; $display("FAIL add_ovf got=%h want=%h", obs, {16'h8000, 6'b010101}); end
    drive(1'b1, 16'h8000, 16'h0001, 2'd2);
    total++;
    if (obs !== {16'h7FFF, 6'b000101}) begin bad++; $display("FAIL sub_ovf got=%h want=%h", obs, {16'h7FFF, 6'b000101}); end
    drive(1'b1, 16'd5, 16'd5, 2'd2);
    total++;
    if (obs !== {16'h0000, 6'b100001}) begin bad++; $display("FAIL sub_zero got=%h want=%h", obs, {16'h0000, 6'b100001}); end
  endtask

  task automatic test_reserved();
    drive(1'b1, 16'h1234, 16'h5678, 2'd3);
    total++;
    if (obs !== {16'h0000, 6'b100011}) begin bad++; $display("FAIL reserved got=%h want=%h", obs, {16'h0000, 6'b100011}); end
  endtask

  task automatic test_hold();
    logic [21:0] exp;
    drive(1'b1, 16'hF00D, 16'h1234, 2'd1);
    exp = model(16'hF00D, 16'h1234, 2'd1);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL hold_add got=%h want=%h", obs, exp); end
    exp[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'($urandom), 16'($urandom), 2'($urandom));
      total++;
      if (obs !== exp) begin bad++; $display("FAIL hold_cycle%0d got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'hFFFF, 16'hFFFF, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL async_clear got=%h want=%h", obs, 22'd0); end
    drive(1'b1, 16'd1, 16'd2, 2'd1);
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL async_held got=%h want=%h", obs, 22'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'd1, 16'd2, 2'd1);
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL async_release got=%h want=%h", obs, 22'd0); end
  endtask

  task automatic test_random();
    logic [21:0] exp;
    logic [15:0] x, y;
    logic [1:0]  op;
    logic        v;
    exp = obs;
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom); y = 16'($urandom); op = 2'($urandom);
      if (i % 7 == 0) y = x;
      if (i % 11 == 0) x = 16'h8000;
      v = ($urandom_range(0, 3) != 0);
      drive(v, x, y, op);
      if (v) exp = model(x, y, op);
      else exp[0] = 1'b0;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random%0d a=%h b=%h op=%0d got=%h want=%h", i, x, y, op, obs, exp); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_op = '0;
    test_reset();
    test_reg_path();
    test_back_to_back();
    test_flags();
    test_reserved();
    test_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
